// File: rtl/mem_arbiter_pkg.sv
// Shared bus and ownership definitions for the processor-memory arbiter.
// Holds the memory bus command encoding, address width, memory tag width
// and the enum naming which requester owns an outstanding load tag.
package mem_arbiter_pkg;

    localparam int XLEN      = 32;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } MEM_OWNER;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory load tags.
// One {valid, owner} entry per tag (tag 0 is never written because memory
// uses it to mean "rejected/none").
// Ports:
//   clock, reset_n   : clock and asynchronous active-low reset
//   wr_en_i          : record an accepted load on wr_tag_i for wr_owner_i
//   rsp_tag_i        : tag of returning data (0 = none)
//   rsp_hit_o        : returning tag is owned; rsp_owner_o says by whom
//   rsp_miss_o       : returning tag is nonzero but not owned
//   wr_collide_o     : write lands on an entry still outstanding
//   count_o          : number of valid entries
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en_i,
    input  logic [MEM_TAG_W-1:0] wr_tag_i,
    input  MEM_OWNER             wr_owner_i,
    input  logic [MEM_TAG_W-1:0] rsp_tag_i,
    output logic                 rsp_hit_o,
    output MEM_OWNER             rsp_owner_o,
    output logic                 rsp_miss_o,
    output logic                 wr_collide_o,
    output logic [4:0]           count_o
);

    logic     valid_q [NUM_TAGS+1];
    logic     valid_d [NUM_TAGS+1];
    MEM_OWNER owner_q [NUM_TAGS+1];
    MEM_OWNER owner_d [NUM_TAGS+1];

    logic rsp_in_range;
    logic wr_in_range;

    assign rsp_in_range = ({1'b0, rsp_tag_i} <= (MEM_TAG_W+1)'(NUM_TAGS));
    assign wr_in_range  = ({1'b0, wr_tag_i}  <= (MEM_TAG_W+1)'(NUM_TAGS));

    // Lookup uses the pre-edge table, so a same-cycle response and new
    // accept on one tag routes to the old owner before the entry is reused.
    always_comb begin
        rsp_hit_o    = 1'b0;
        rsp_owner_o  = OWNER_IC;
        rsp_miss_o   = 1'b0;
        wr_collide_o = 1'b0;
        if (rsp_tag_i != '0) begin
            if (rsp_in_range && valid_q[rsp_tag_i]) begin
                rsp_hit_o   = 1'b1;
                rsp_owner_o = owner_q[rsp_tag_i];
            end else begin
                rsp_miss_o = 1'b1;
            end
        end
        if (wr_en_i && wr_in_range && valid_q[wr_tag_i] &&
            !(rsp_hit_o && (rsp_tag_i == wr_tag_i))) begin
            wr_collide_o = 1'b1;
        end
    end

    // Clear on response first, then apply the write so a reused tag ends valid.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        if (rsp_hit_o) begin
            valid_d[rsp_tag_i] = 1'b0;
        end
        if (wr_en_i && wr_in_range) begin
            valid_d[wr_tag_i] = 1'b1;
            owner_d[wr_tag_i] = wr_owner_i;
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            count_o = count_o + 5'(valid_q[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                valid_q[i] <= 1'b0;
                owner_q[i] <= OWNER_IC;
            end
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single processor-memory bus shared by the Icache miss
// path and the Dcache. Dcache has priority, but a streak counter forces an
// Icache grant after STREAK_MAX back-to-back Dcache grants while Icache waits.
// Accepted loads are tagged in mem_tag_table so returning data can be routed.
// Ports:
//   clock, reset_n                       : clock, asynchronous active-low reset
//   ic_req/ic_addr -> ic_accept          : Icache load request and handshake
//   ic_resp_valid/ic_resp_data           : load data returned to Icache
//   dc_cmd/dc_addr/dc_wdata -> dc_accept : Dcache command and handshake
//   dc_resp_valid/dc_resp_data           : load data returned to Dcache
//   proc2mem_command/addr/data           : command driven to memory
//   mem2proc_response/data/tag           : accept tag, returning data and tag
//   tag_error                            : sticky tag-protocol violation flag
//   outstanding_debug                    : number of owned tags
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS   = 15,
    parameter int STREAK_MAX = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ic_req,
    input  logic [XLEN-1:0]      ic_addr,
    output logic                 ic_accept,
    output logic                 ic_resp_valid,
    output logic [63:0]          ic_resp_data,
    input  BUS_COMMAND           dc_cmd,
    input  logic [XLEN-1:0]      dc_addr,
    input  logic [63:0]          dc_wdata,
    output logic                 dc_accept,
    output logic                 dc_resp_valid,
    output logic [63:0]          dc_resp_data,
    output BUS_COMMAND           proc2mem_command,
    output logic [XLEN-1:0]      proc2mem_addr,
    output logic [63:0]          proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag,
    output logic                 tag_error,
    output logic [4:0]           outstanding_debug
);

    localparam int STREAK_W = $clog2(STREAK_MAX + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                tag_error_q, tag_error_d;

    logic     grant_ic, grant_dc;
    logic     table_full;
    logic     streak_open;
    logic     wr_en;
    MEM_OWNER wr_owner;
    logic     rsp_hit, rsp_miss, wr_collide;
    MEM_OWNER rsp_owner;

    assign table_full  = (outstanding_debug == 5'(NUM_TAGS));
    assign streak_open = (streak_q < STREAK_W'(STREAK_MAX));

    // Grant is gated by reset_n so every output reads zero while reset is
    // held, even though the requesters may still be driving.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (reset_n && !table_full) begin
            if ((dc_cmd != BUS_NONE) && (streak_open || !ic_req)) begin
                grant_dc = 1'b1;
            end else if (ic_req) begin
                grant_ic = 1'b1;
            end
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_dc) begin
            proc2mem_command = dc_cmd;
            proc2mem_addr    = dc_addr;
            proc2mem_data    = dc_wdata;
        end else if (grant_ic) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ic_addr;
        end
    end

    assign ic_accept = grant_ic && (mem2proc_response != '0);
    assign dc_accept = grant_dc && (mem2proc_response != '0);

    // Stores get no data back, so only loads occupy a table entry.
    assign wr_en    = ic_accept || (dc_accept && (dc_cmd == BUS_LOAD));
    assign wr_owner = ic_accept ? OWNER_IC : OWNER_DC;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en_i      (wr_en),
        .wr_tag_i     (mem2proc_response),
        .wr_owner_i   (wr_owner),
        .rsp_tag_i    (mem2proc_tag),
        .rsp_hit_o    (rsp_hit),
        .rsp_owner_o  (rsp_owner),
        .rsp_miss_o   (rsp_miss),
        .wr_collide_o (wr_collide),
        .count_o      (outstanding_debug)
    );

    assign ic_resp_valid = rsp_hit && (rsp_owner == OWNER_IC);
    assign dc_resp_valid = rsp_hit && (rsp_owner == OWNER_DC);
    assign ic_resp_data  = ic_resp_valid ? mem2proc_data : '0;
    assign dc_resp_data  = dc_resp_valid ? mem2proc_data : '0;

    // Streak only counts Dcache wins that actually made Icache wait.
    always_comb begin
        streak_d = streak_q;
        if (!ic_req || ic_accept) begin
            streak_d = '0;
        end else if (dc_accept && streak_open) begin
            streak_d = streak_q + 1'b1;
        end
    end

    assign tag_error_d = tag_error_q || rsp_miss || wr_collide;
    assign tag_error   = tag_error_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak_q    <= '0;
            tag_error_q <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            tag_error_q <= tag_error_d;
        end
    end

endmodule
